// File: rtl/fp16_mac_pkg.sv
// Shared definitions for the FP16 multiply-accumulate sequencer: FSM states,
// FP16 field positions and constants, and small field helpers.
package fp16_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [4:0]  FP16_EXP_INF  = 5'h1F;
  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam int          FP16_EXP_MSB  = 14;
  localparam int          FP16_EXP_LSB  = 10;
  localparam int          FP16_MANT_MSB = 9;
  localparam int          FP16_MANT_LSB = 0;

  function automatic logic [4:0] fp16_exp(input logic [15:0] v);
    return v[FP16_EXP_MSB:FP16_EXP_LSB];
  endfunction

  function automatic logic [9:0] fp16_mant(input logic [15:0] v);
    return v[FP16_MANT_MSB:FP16_MANT_LSB];
  endfunction

  function automatic logic fp16_exp_is_max(input logic [15:0] v);
    return fp16_exp(v) == FP16_EXP_INF;
  endfunction

endpackage

// File: rtl/fp16_dot_seq.sv
// Dot-product sequencer: issues operand pairs one at a time to the FP16 MAC
// datapath, feeds each result back as the next accumulator, presents the sum.
module fp16_dot_seq
  import fp16_mac_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mac_issue,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic [15:0]      mac_acc,
  input  logic [15:0]      mac_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [WCW-1:0]   r_wcnt;
  logic [15:0]      r_acc;
  logic             r_first;
  logic             r_busy;
  logic             r_in_ready;
  logic             r_mac_issue;
  logic [15:0]      r_mac_a;
  logic [15:0]      r_mac_b;
  logic [15:0]      r_mac_acc;
  logic             r_out_valid;
  logic [15:0]      r_out_data;
  logic             r_out_ovf;

  logic w_in_hs;
  logic w_last;
  logic w_wait_done;

  assign w_in_hs     = in_valid && r_in_ready;
  assign w_last      = (r_remaining == LEN_W'(1));
  assign w_wait_done = (r_wcnt == WCW'(0));

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_wcnt      <= '0;
      r_acc       <= FP16_ZERO;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mac_issue <= 1'b0;
      r_mac_a     <= FP16_ZERO;
      r_mac_b     <= FP16_ZERO;
      r_mac_acc   <= FP16_ZERO;
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_ZERO;
      r_out_ovf   <= 1'b0;
    end else begin
      r_mac_issue <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remaining <= cfg_len;
            r_acc       <= FP16_ZERO;
            r_out_ovf   <= 1'b0;
            r_first     <= 1'b1;
            r_out_data  <= FP16_ZERO;
            r_busy      <= 1'b1;
            if (cfg_len == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ST_FETCH;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (w_in_hs) begin
            r_mac_a     <= in_a;
            r_mac_b     <= in_b;
            r_mac_acc   <= r_first ? FP16_ZERO : r_acc;
            r_in_ready  <= 1'b0;
            r_mac_issue <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wcnt  <= WCW'(LAT - 1);
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // The datapath result is only trusted on the final wait cycle.
          if (w_wait_done) begin
            r_acc       <= mac_res;
            r_remaining <= r_remaining - LEN_W'(1);
            r_first     <= 1'b0;
            r_out_ovf   <= r_out_ovf | fp16_exp_is_max(mac_res);
            if (w_last) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_out_data  <= mac_res;
            end else begin
              r_state    <= ST_FETCH;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_wcnt <= r_wcnt - WCW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign mac_issue = r_mac_issue;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_acc   = r_mac_acc;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Directed bench for fp16_dot_seq with a scripted fixed-latency datapath model
// that returns junk (an infinity pattern) outside the capture cycle.
module tb_fp16_dot_seq;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_len = 8'd0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = 16'h0000;
  logic [15:0] in_b = 16'h0000;
  logic        mac_issue;
  logic [15:0] mac_a, mac_b, mac_acc, mac_res;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;

  fp16_dot_seq #(.LAT(LAT), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_issue(mac_issue), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .mac_res(mac_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_issue = 0;
  int cyc = 0;
  int age = 200;
  logic [15:0] res_cur = 16'hFC00;
  logic [15:0] q_a[$], q_b[$], q_acc[$], q_res[$];
  logic [15:0] va[4], vb[4];

  assign mac_res = (age == LAT) ? res_cur : 16'hFC00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] acc, input logic [15:0] res);
    q_a.push_back(a); q_b.push_back(b); q_acc.push_back(acc); q_res.push_back(res);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model and issue/ready monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      age     <= 200;
      res_cur <= 16'hFC00;
    end else if (mac_issue) begin
      n_issue <= n_issue + 1;
      check_eq("issue_1cyc", {31'd0, age != 0}, 32'd1);
      if (q_a.size() > 0) begin
        check_eq("mac_a", {16'd0, mac_a}, {16'd0, q_a.pop_front()});
        check_eq("mac_b", {16'd0, mac_b}, {16'd0, q_b.pop_front()});
        check_eq("mac_acc", {16'd0, mac_acc}, {16'd0, q_acc.pop_front()});
        res_cur <= q_res.pop_front();
      end else begin
        check_eq("unexp_issue", 32'd1, 32'd0);
        res_cur <= 16'hFC00;
      end
      age <= 0;
    end else if (age < 200) begin
      age <= age + 1;
    end
    if (in_ready && !rst)
      check_eq("rdy_fetch", {31'd0, (age >= LAT) && !mac_issue && !out_valid}, 32'd1);
  end

  task automatic run_vec(input int n, input bit gaps, input bit restart,
                         output int s_cyc, output int ov_cyc);
    int k;
    bit take;
    @(negedge clk);
    s_cyc = cyc; start = 1'b1; cfg_len = n[7:0]; k = 0; take = 1'b0;
    in_a = va[0]; in_b = vb[0]; in_valid = (n > 0) && !gaps;
    ov_cyc = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (restart && t == 3) begin
        start = 1'b1; cfg_len = 8'd5;
      end
      if (take) begin k++; take = 1'b0; end
      if (out_valid) begin ov_cyc = cyc; break; end
      if (k < n) begin
        in_a = va[k]; in_b = vb[k];
        in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      take = in_valid && in_ready;
    end
    in_valid = 1'b0; start = 1'b0;
    check_eq("no_timeout", {31'd0, ov_cyc >= 0}, 32'd1);
  endtask

  task automatic drain(input int hold, input logic [15:0] exp_d, input logic exp_ovf);
    int iss0;
    iss0 = n_issue;
    check_eq("out_data", {16'd0, out_data}, {16'd0, exp_d});
    check_eq("out_ovf", {31'd0, out_ovf}, {31'd0, exp_ovf});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      check_eq("hold_data", {16'd0, out_data}, {16'd0, exp_d});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("idle_after", {30'd0, out_valid, busy}, 32'd0);
    check_eq("no_extra_issue", n_issue, iss0);
  endtask

  initial begin
    int s, ov, iss0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_outs", {busy, in_ready, mac_issue, out_valid, out_ovf, 27'd0}, 32'd0);
    check_eq("rst_data", {out_data, mac_a}, 32'd0);
    check_eq("rst_acc", {mac_b, mac_acc}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-element product 1*2 + 2*3 = 8.
    va[0] = 16'h3C00; vb[0] = 16'h4000; va[1] = 16'h4000; vb[1] = 16'h4200;
    push(16'h3C00, 16'h4000, 16'h0000, 16'h4000);
    push(16'h4000, 16'h4200, 16'h4000, 16'h4800);
    run_vec(2, 1'b0, 1'b0, s, ov);
    check_eq("lat_len2", ov - s, 32'd11);
    check_eq("busy_done", {31'd0, busy}, 32'd1);
    drain(0, 16'h4800, 1'b0);

    // Gapped input and a stalled output.
    va[0] = 16'h3C00; vb[0] = 16'h3C00; va[1] = 16'h3C00; vb[1] = 16'h4000;
    va[2] = 16'h4000; vb[2] = 16'h3C00;
    push(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00);
    push(16'h3C00, 16'h4000, 16'h3C00, 16'h4200);
    push(16'h4000, 16'h3C00, 16'h4200, 16'h4500);
    run_vec(3, 1'b1, 1'b0, s, ov);
    drain(5, 16'h4500, 1'b0);

    // Zero-length vector.
    iss0 = n_issue;
    run_vec(0, 1'b0, 1'b0, s, ov);
    check_eq("lat_len0", ov - s, 32'd1);
    check_eq("len0_issue", n_issue, iss0);
    drain(0, 16'h0000, 1'b0);

    // Infinity on the first element sets the sticky overflow.
    va[0] = 16'h3C00; vb[0] = 16'h3C00; va[1] = 16'h3C00; vb[1] = 16'h3C00;
    va[2] = 16'h3C00; vb[2] = 16'h3C00;
    push(16'h3C00, 16'h3C00, 16'h0000, 16'h7C00);
    push(16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00);
    push(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000);
    run_vec(3, 1'b0, 1'b0, s, ov);
    drain(0, 16'h4000, 1'b1);

    // Reset during the wait of element 2.
    push(16'h3C00, 16'h3C00, 16'h0000, 16'h3C00);
    push(16'h3C00, 16'h3C00, 16'h3C00, 16'h4000);
    iss0 = n_issue;
    @(negedge clk);
    start = 1'b1; cfg_len = 8'd3; in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h3C00;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 100 && n_issue < iss0 + 2; t++) @(negedge clk);
    check_eq("rst_reach_e2", n_issue, iss0 + 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_outs", {busy, in_ready, mac_issue, out_valid, out_ovf, 27'd0}, 32'd0);
    check_eq("rst_mid_data", {out_data, mac_a}, 32'd0);
    check_eq("rst_mid_acc", {mac_b, mac_acc}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q_a.delete(); q_b.delete(); q_acc.delete(); q_res.delete();
    @(negedge clk);
    check_eq("post_rst_idle", {30'd0, out_valid, busy}, 32'd0);
    va[0] = 16'h4000; vb[0] = 16'h4000;
    push(16'h4000, 16'h4000, 16'h0000, 16'h4400);
    run_vec(1, 1'b0, 1'b0, s, ov);
    check_eq("lat_len1", ov - s, 32'd6);
    drain(0, 16'h4400, 1'b0);

    // Restart and length change while busy are ignored.
    va[0] = 16'h4000; vb[0] = 16'h4000; va[1] = 16'h3C00; vb[1] = 16'h3C00;
    push(16'h4000, 16'h4000, 16'h0000, 16'h4400);
    push(16'h3C00, 16'h3C00, 16'h4400, 16'h4500);
    iss0 = n_issue;
    run_vec(2, 1'b0, 1'b1, s, ov);
    check_eq("lat_restart", ov - s, 32'd11);
    check_eq("restart_count", n_issue - iss0, 32'd2);
    drain(0, 16'h4500, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp16_dot_seq.md
# fp16_dot_seq

Sequencer that drives the FP16 multiply-accumulate datapath (multiplier, aligner/adder, normalizer) through a dot product of `cfg_len` operand pairs. It accepts pairs over a valid/ready stream and issues them one at a time, because each accumulate depends on the previous result. It waits the datapath's fixed latency, captures each normalized result as the next accumulator operand, and presents the final sum on a valid/ready output. It sits between the operand fetch logic and the MAC datapath.

## Interface
- `LAT`, 3: datapath latency in cycles from `mac_issue` to a valid `mac_res`; must be ≥1.
- `LEN_W`, 8: width of the element count.
- `clk` in 1: the single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begins a vector; honoured only in IDLE.
- `cfg_len` in LEN_W: number of pairs; sampled on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `in_valid` in 1, `in_ready` out 1, `in_a` in 16, `in_b` in 16: operand stream in FP16.
- `mac_issue` out 1: one-cycle pulse that starts one datapath operation.
- `mac_a` out 16, `mac_b` out 16, `mac_acc` out 16: datapath operands, registered and held from ISSUE through WAIT.
- `mac_res` in 16: datapath result {sign, exp[14:10], mant[9:0]}.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 16: final sum.
- `out_ovf` out 1: sticky; set if any captured result had exponent 5'h1F.

## Operation
- States:
  - IDLE → FETCH on `start` with `cfg_len`≠0.
  - IDLE → DONE on `start` with `cfg_len`=0.
  - FETCH → ISSUE on an `in_valid`&&`in_ready` handshake.
  - ISSUE → WAIT after exactly 1 cycle.
  - WAIT → FETCH or DONE after exactly LAT cycles.
  - DONE → IDLE on `out_valid`&&`out_ready`.
- On `start` accept:
  - `remaining`←`cfg_len`.
  - accumulator `acc`←16'h0000.
  - `out_ovf`←0.
  - `first`←1.
- FETCH: `in_ready`=1. On handshake, `mac_a`←`in_a` and `mac_b`←`in_b`. `mac_acc`←16'h0000 if `first`, else `acc`.
- ISSUE: `mac_issue`=1 for exactly this cycle.
- WAIT: counter `wcnt` runs from LAT-1 down to 0. On the edge where `wcnt`=0:
  - `acc`←`mac_res`.
  - `remaining`←`remaining`-1.
  - `first`←0.
  - `out_ovf`←`out_ovf` | (`mac_res[14:10]`==5'h1F).
  - Next state is DONE if `remaining` was 1, else FETCH.
- DONE: `out_valid`=1 and `out_data`=`acc`. Both are held stable until `out_ready`.
- `mac_res` is ignored outside the capture edge.
- `start` outside IDLE is ignored. `cfg_len` changes mid-vector are ignored.
- `in_ready` is 0 in every state except FETCH.
- The block performs no arithmetic on data. Overflow detection is an exponent compare only. Infinity propagates unchanged via the datapath.

## Timing
- Reset value of every output is 0, including `out_data`=16'h0000, `mac_a`/`mac_b`/`mac_acc`=0 and `out_ovf`=0. State resets to IDLE.
- Reset asserted mid-vector:
  - All outputs clear immediately, asynchronously.
  - Any in-flight datapath result is discarded.
  - No partial result is ever presented.
- Let T be the ISSUE cycle. The capture edge closes cycle T+LAT. The next FETCH or DONE is cycle T+LAT+1.
- Element period is LAT+2 cycles when `in_valid` is already high.
- From the `start` cycle S, with inputs always valid, `out_valid` first rises in cycle S+1+N·(LAT+2).
- `cfg_len`=0: `out_valid` rises in cycle S+1 with `out_data`=16'h0000.
- The `out_ready` handshake in DONE returns to IDLE the next cycle. `start` is accepted in IDLE no earlier than that cycle.

## Structure
- Shared package `fp16_mac_pkg` holds:
  - the state enum (IDLE, FETCH, ISSUE, WAIT, DONE)
  - `FP16_EXP_INF` = 5'h1F
  - `FP16_ZERO` = 16'h0000
  - the FP16 field slice positions (exp [14:10], mant [9:0])
- Single module with no sub-module. The LAT counter and element counter are inline.

## Test plan
- LAT=3, len=2, pairs (3C00,4000) and (4000,4200); the model computes acc+a·b:
  - First issue has `mac_acc`=0000; second issue has `mac_acc`=4000.
  - `out_data`=4800 with `out_valid` in cycle S+11.
- `in_valid` with random gaps and `out_ready` held low for 5 cycles in DONE:
  - `in_ready` is high only in FETCH.
  - `out_data` stays stable with no extra `mac_issue`.
- `cfg_len`=0: `out_valid`=1 in cycle S+1 with `out_data`=0000 and `out_ovf`=0, and `mac_issue` never pulses.
- len=3, model returns 7C00 on element 1 and finite values after: `out_ovf`=1 at DONE.
- `rst` pulse during WAIT of element 2:
  - All outputs read 0 within the same cycle.
  - A later `start` with len=1 gives a correct result with `mac_acc`=0000.
- `start` pulsed and `cfg_len` changed while busy: no restart, and the count still equals the originally sampled length.
